// File: rtl/axil_lfsr_stream_if.sv
// AXI-Lite control port and AXI-Stream output of the LFSR pattern generator.
// "slave" is the generator's view; "master" is the processor/consumer view.
interface axil_lfsr_stream_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [DATA_WIDTH-1:0] s_axi_wdata;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [DATA_WIDTH-1:0] s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;
    logic [31:0]           m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready, m_axis_tready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        output s_axi_araddr, s_axi_arvalid, s_axi_rready, m_axis_tready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/axil_lfsr_stream.sv
// AXI-Lite configured Fibonacci/Galois LFSR source with an AXI-Stream output,
// optional burst length with TLAST, saturating sent-word counter and seed error.
module axil_lfsr_stream #(
    parameter int unsigned           LFSR_WIDTH        = 8,
    parameter int unsigned           C_AXIL_ADDR_WIDTH = 5,
    parameter int unsigned           C_AXIL_DATA_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED      = LFSR_WIDTH'(1),
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_TAPS      = LFSR_WIDTH'(8'hB8)
) (
    input logic               aclk,
    input logic               aresetn,
    axil_lfsr_stream_if.slave bus
);
    localparam int unsigned IDX_W = C_AXIL_ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] REG_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] REG_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] REG_SEED   = IDX_W'(2);
    localparam logic [IDX_W-1:0] REG_TAPS   = IDX_W'(3);
    localparam logic [IDX_W-1:0] REG_COUNT  = IDX_W'(4);
    localparam logic [IDX_W-1:0] REG_SENT   = IDX_W'(5);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t                         state_q, state_d;
    logic [LFSR_WIDTH-1:0]          seed_q, taps_q, act_taps_q, lfsr_q, lfsr_next;
    logic [C_AXIL_DATA_WIDTH-1:0]   count_q, act_count_q, sent_q, rdata_q, rd_word;
    logic                           mode_q, act_galois_q, err_q;
    logic                           bvalid_q, rvalid_q;
    logic [1:0]                     bresp_q, rresp_q;
    logic                           wr_fire, rd_fire, wr_ok, rd_ok, beat_fire, is_last;
    logic                           start_req, stop_req, start_go, seed_err;
    logic                           tvalid, tlast, running;
    logic [IDX_W-1:0]               wr_idx, rd_idx;
    logic                           unused_addr_bits;

    assign unused_addr_bits = ^{bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0]};

    // Ready is combinational on the valids so a write completes in the cycle both arrive.
    assign wr_fire = bus.s_axi_awvalid & bus.s_axi_wvalid & ~bvalid_q;
    assign rd_fire = bus.s_axi_arvalid & ~rvalid_q;
    assign wr_idx  = bus.s_axi_awaddr[C_AXIL_ADDR_WIDTH-1:2];
    assign rd_idx  = bus.s_axi_araddr[C_AXIL_ADDR_WIDTH-1:2];

    assign start_req = wr_fire && wr_idx == REG_CTRL && bus.s_axi_wdata[0] && !bus.s_axi_wdata[1];
    assign stop_req  = wr_fire && wr_idx == REG_CTRL && bus.s_axi_wdata[1];
    assign start_go  = state_q == ST_IDLE && start_req && seed_q != '0;
    assign seed_err  = state_q == ST_IDLE && start_req && seed_q == '0;
    assign beat_fire = tvalid & bus.m_axis_tready;
    assign is_last   = act_count_q != '0 && sent_q == act_count_q - 1'b1;

    // NOTE: every always_comb assigns each output first, so no path can infer a latch.
    always_comb begin
        wr_ok = 1'b0;
        case (wr_idx)
            REG_CTRL, REG_SEED, REG_TAPS, REG_COUNT: wr_ok = 1'b1;
            default:                                 wr_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b1;
        case (rd_idx)
            REG_CTRL:   rd_word = C_AXIL_DATA_WIDTH'({mode_q, 2'b00});
            REG_STATUS: rd_word = C_AXIL_DATA_WIDTH'({err_q, running});
            REG_SEED:   rd_word = C_AXIL_DATA_WIDTH'(seed_q);
            REG_TAPS:   rd_word = C_AXIL_DATA_WIDTH'(taps_q);
            REG_COUNT:  rd_word = count_q;
            REG_SENT:   rd_word = sent_q;
            default:    rd_ok   = 1'b0;
        endcase
    end

    // NOTE: clocked blocks use non-blocking (<=) so all registers sample pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seed_q   <= DEFAULT_SEED;
            taps_q   <= DEFAULT_TAPS;
            count_q  <= '0;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (seed_err) err_q <= 1'b1;
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                case (wr_idx)
                    REG_CTRL: mode_q <= bus.s_axi_wdata[2];
                    REG_SEED: begin
                        seed_q <= bus.s_axi_wdata[LFSR_WIDTH-1:0];
                        err_q  <= 1'b0;
                    end
                    REG_TAPS:  taps_q  <= bus.s_axi_wdata[LFSR_WIDTH-1:0];
                    REG_COUNT: count_q <= bus.s_axi_wdata;
                    default: ;
                endcase
            end else if (bus.s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bus.s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // Configuration is snapshotted at start so writes during a burst wait for the next one.
    always_comb begin
        if (act_galois_q)
            lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? act_taps_q : '0);
        else
            lfsr_next = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & act_taps_q)};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_q       <= '0;
            sent_q       <= '0;
            act_taps_q   <= DEFAULT_TAPS;
            act_count_q  <= '0;
            act_galois_q <= 1'b0;
        end else if (start_go) begin
            lfsr_q       <= seed_q;
            sent_q       <= '0;
            act_taps_q   <= taps_q;
            act_count_q  <= count_q;
            act_galois_q <= bus.s_axi_wdata[2];
        end else if (beat_fire) begin
            lfsr_q <= lfsr_next;
            if (sent_q != '1) sent_q <= sent_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_go) state_d = ST_RUN;
            ST_RUN: begin
                if (beat_fire && is_last) state_d = ST_IDLE;
                else if (stop_req)        state_d = ST_DRAIN;
            end
            ST_DRAIN: if (beat_fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tvalid  = state_q != ST_IDLE;
        running = state_q != ST_IDLE;
        tlast   = state_q == ST_DRAIN || (state_q == ST_RUN && is_last);
    end

    assign bus.s_axi_awready = wr_fire;
    assign bus.s_axi_wready  = wr_fire;
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign bus.s_axi_arready = rd_fire;
    assign bus.s_axi_rvalid  = rvalid_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.s_axi_rresp   = rresp_q;
    assign bus.m_axis_tdata  = 32'(lfsr_q);
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tlast  = tlast;
endmodule

// File: tb/tb_axil_lfsr_stream.sv
// Bench for axil_lfsr_stream: register access, fixed and random bursts checked
// against an arithmetic LFSR model, stop/drain, seed error and async reset.
module tb_axil_lfsr_stream;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [32:0] beat_q[$];

    axil_lfsr_stream_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus();

    axil_lfsr_stream #(
        .LFSR_WIDTH(8), .C_AXIL_ADDR_WIDTH(5), .C_AXIL_DATA_WIDTH(32),
        .DEFAULT_SEED(8'h01), .DEFAULT_TAPS(8'hB8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    always #5 aclk = ~aclk;

    // A handshake seen at the falling edge completes at the following rising edge.
    always @(negedge aclk)
        if (aresetn && bus.m_axis_tvalid && bus.m_axis_tready)
            beat_q.push_back({bus.m_axis_tlast, bus.m_axis_tdata});

    function automatic logic [7:0] ref_next(input logic [7:0] s, input logic [7:0] t, input bit galois);
        int unsigned si = 32'(s);
        int unsigned ti = 32'(t);
        if (galois) return 8'((si / 2) ^ ((si % 2) * ti));
        return 8'(((si * 2) % 256) + ($countones(si & ti) % 2));
    endfunction

    task automatic axil_write(input logic [4:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        @(posedge aclk); #1;
        bus.s_axi_awaddr = addr; bus.s_axi_wdata = data;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        @(negedge aclk);
        while (!(bus.s_axi_awready && bus.s_axi_wready) && n < 20) begin @(negedge aclk); n++; end
        @(posedge aclk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!bus.s_axi_bvalid && n < 20) begin @(negedge aclk); n++; end
        if (!bus.s_axi_bvalid) begin
            total++; bad++; resp = 2'bxx;
            $display("FAIL write_timeout addr=%h: no bvalid, required bvalid=1", addr);
        end else resp = bus.s_axi_bresp;
    endtask

    task automatic axil_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        @(posedge aclk); #1;
        bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1;
        @(negedge aclk);
        while (!bus.s_axi_arready && n < 20) begin @(negedge aclk); n++; end
        @(posedge aclk); #1;
        bus.s_axi_arvalid = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!bus.s_axi_rvalid && n < 20) begin @(negedge aclk); n++; end
        if (!bus.s_axi_rvalid) begin
            total++; bad++; data = 'x; resp = 2'bxx;
            $display("FAIL read_timeout addr=%h: no rvalid, required rvalid=1", addr);
        end else begin
            data = bus.s_axi_rdata; resp = bus.s_axi_rresp;
        end
    endtask

    task automatic wait_beats(input int want, input int budget);
        int n = 0;
        while (beat_q.size() < want && n < budget) begin @(negedge aclk); n++; end
        if (beat_q.size() < want) begin
            total++; bad++;
            $display("FAIL beat_timeout got=%0d required=%0d", beat_q.size(), want);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        total++;
        if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, bus.s_axi_bvalid, bus.s_axi_rvalid,
             bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_rdata, bus.s_axi_bresp, bus.s_axi_rresp} !== '0) begin
            bad++;
            $display("FAIL reset_outputs tvalid=%b tlast=%b tdata=%h bvalid=%b rvalid=%b rdata=%h required all 0",
                     bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, bus.s_axi_bvalid,
                     bus.s_axi_rvalid, bus.s_axi_rdata);
        end
        @(negedge aclk); aresetn = 1'b1;
        axil_read(5'h08, d, r);
        total++; if (d !== 32'h01 || r !== 2'b00) begin bad++; $display("FAIL reset_seed got=%h/%b required=00000001/00", d, r); end
        axil_read(5'h0C, d, r);
        total++; if (d !== 32'hB8 || r !== 2'b00) begin bad++; $display("FAIL reset_taps got=%h/%b required=000000b8/00", d, r); end
        axil_read(5'h10, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_count got=%h required=0", d); end
        axil_read(5'h04, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h required=0", d); end
        axil_read(5'h18, d, r);
        total++; if (r !== 2'b10) begin bad++; $display("FAIL unmapped_read resp=%b required=10", r); end
        axil_write(5'h04, 32'hFFFF_FFFF, r);
        total++; if (r !== 2'b10) begin bad++; $display("FAIL status_write resp=%b required=10", r); end
        axil_write(5'h14, 32'h1234, r);
        total++; if (r !== 2'b10) begin bad++; $display("FAIL sent_write resp=%b required=10", r); end
        axil_read(5'h14, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL sent_after_slverr got=%h required=0", d); end
    endtask

    task automatic test_fibonacci();
        logic [31:0] d; logic [1:0] r;
        logic [7:0] exp_beats[5] = '{8'h42, 8'h84, 8'h08, 8'h10, 8'h21};
        beat_q.delete();
        bus.m_axis_tready = 1'b1;
        axil_write(5'h08, 32'hABCD_0042, r);
        total++; if (r !== 2'b00) begin bad++; $display("FAIL seed_write resp=%b required=00", r); end
        axil_read(5'h08, d, r);
        total++; if (d !== 32'h42) begin bad++; $display("FAIL seed_mask got=%h required=00000042", d); end
        axil_write(5'h0C, 32'hB4, r);
        axil_write(5'h10, 32'd5, r);
        axil_write(5'h00, 32'h1, r);
        wait_beats(5, 50);
        repeat (4) @(negedge aclk);
        total++; if (beat_q.size() !== 5) begin bad++; $display("FAIL fib_beats got=%0d required=5", beat_q.size()); end
        for (int i = 0; i < 5 && i < beat_q.size(); i++) begin
            total++;
            if (beat_q[i] !== {(i == 4), 24'h0, exp_beats[i]}) begin
                bad++;
                $display("FAIL fib_beat%0d got=%h required=%h", i, beat_q[i], {(i == 4), 24'h0, exp_beats[i]});
            end
        end
        axil_read(5'h14, d, r);
        total++; if (d !== 32'd5) begin bad++; $display("FAIL fib_sent got=%0d required=5", d); end
        axil_read(5'h04, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL fib_status got=%h required=0", d); end
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL fib_idle tvalid=%b required=0", bus.m_axis_tvalid); end
    endtask

    task automatic test_galois();
        logic [31:0] d; logic [1:0] r;
        logic [7:0] s = 8'h01;
        beat_q.delete();
        bus.m_axis_tready = 1'b1;
        axil_write(5'h08, 32'h01, r);
        axil_write(5'h0C, 32'hB8, r);
        axil_write(5'h10, 32'd256, r);
        axil_write(5'h00, 32'h5, r);
        wait_beats(256, 400);
        repeat (4) @(negedge aclk);
        total++; if (beat_q.size() !== 256) begin bad++; $display("FAIL gal_beats got=%0d required=256", beat_q.size()); end
        for (int i = 0; i < 256 && i < beat_q.size(); i++) begin
            total++;
            if (beat_q[i] !== {(i == 255), 24'h0, s}) begin
                bad++;
                $display("FAIL gal_beat%0d got=%h required=%h", i, beat_q[i], {(i == 255), 24'h0, s});
            end
            s = ref_next(s, 8'hB8, 1'b1);
        end
        if (beat_q.size() >= 256) begin
            total++; if (beat_q[255][31:0] !== 32'h01) begin bad++; $display("FAIL gal_period got=%h required=00000001", beat_q[255][31:0]); end
        end
        axil_read(5'h14, d, r);
        total++; if (d !== 32'd256) begin bad++; $display("FAIL gal_sent got=%0d required=256", d); end
    endtask

    task automatic test_stop_random();
        logic [31:0] d; logic [1:0] r;
        logic [7:0] seed = 8'($urandom_range(1, 255));
        logic [7:0] taps = 8'($urandom_range(1, 255));
        bit galois = 1'($urandom_range(0, 1));
        logic [7:0] exp_s;
        int k = 0;
        bus.m_axis_tready = 1'b0;
        axil_write(5'h08, 32'(seed), r);
        axil_write(5'h0C, 32'(taps), r);
        axil_write(5'h10, 32'd0, r);
        axil_write(5'h00, 32'({galois, 2'b01}), r);
        exp_s = seed;
        for (int c = 0; c < 100; c++) begin
            @(posedge aclk); #1;
            bus.m_axis_tready = 1'($urandom_range(0, 1));
            @(negedge aclk);
            total++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 32'(exp_s) || bus.m_axis_tlast !== 1'b0) begin
                bad++;
                $display("FAIL run_beat%0d valid/last/data got=%b/%b/%h required=1/0/%h",
                         k, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, 32'(exp_s));
            end
            if (bus.m_axis_tready) begin exp_s = ref_next(exp_s, taps, galois); k++; end
        end
        @(posedge aclk); #1;
        bus.m_axis_tready = 1'b0;
        axil_write(5'h00, 32'h2, r);
        repeat (3) begin
            @(negedge aclk);
            total++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tlast !== 1'b1 || bus.m_axis_tdata !== 32'(exp_s)) begin
                bad++;
                $display("FAIL drain_hold valid/last/data got=%b/%b/%h required=1/1/%h",
                         bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, 32'(exp_s));
            end
        end
        @(posedge aclk); #1;
        bus.m_axis_tready = 1'b1;
        @(negedge aclk);
        total++;
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tlast !== 1'b1 || bus.m_axis_tdata !== 32'(exp_s)) begin
            bad++;
            $display("FAIL drain_final valid/last/data got=%b/%b/%h required=1/1/%h",
                     bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, 32'(exp_s));
        end
        k++;
        @(posedge aclk); #1;
        bus.m_axis_tready = 1'b0;
        @(negedge aclk);
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL drain_done tvalid=%b required=0", bus.m_axis_tvalid); end
        axil_read(5'h14, d, r);
        total++; if (d !== 32'(k)) begin bad++; $display("FAIL stop_sent got=%0d required=%0d", d, k); end
        axil_read(5'h04, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL stop_status got=%h required=0", d); end
    endtask

    task automatic test_seed_zero();
        logic [31:0] d; logic [1:0] r;
        beat_q.delete();
        bus.m_axis_tready = 1'b1;
        axil_write(5'h08, 32'h0, r);
        axil_write(5'h00, 32'h1, r);
        total++; if (r !== 2'b00) begin bad++; $display("FAIL zero_start resp=%b required=00", r); end
        repeat (5) begin
            @(negedge aclk);
            total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL zero_tvalid got=%b required=0", bus.m_axis_tvalid); end
        end
        axil_read(5'h04, d, r);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL zero_status got=%h required=00000002", d); end
        axil_write(5'h08, 32'h05, r);
        axil_read(5'h04, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL zero_clear got=%h required=0", d); end
        total++; if (beat_q.size() !== 0) begin bad++; $display("FAIL zero_beats got=%0d required=0", beat_q.size()); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic [1:0] r;
        bus.m_axis_tready = 1'b1;
        axil_write(5'h0C, 32'h8E, r);
        axil_write(5'h08, 32'h33, r);
        axil_write(5'h10, 32'd0, r);
        axil_write(5'h00, 32'h5, r);
        repeat (10) @(negedge aclk);
        total++; if (bus.m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL ares_running tvalid=%b required=1", bus.m_axis_tvalid); end
        #2 aresetn = 1'b0;
        #1;
        total++;
        if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0 || bus.m_axis_tdata !== 32'h0) begin
            bad++;
            $display("FAIL ares_outputs valid/last/data got=%b/%b/%h required=0/0/0",
                     bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata);
        end
        @(negedge aclk); @(negedge aclk);
        aresetn = 1'b1;
        axil_read(5'h08, d, r);
        total++; if (d !== 32'h01) begin bad++; $display("FAIL ares_seed got=%h required=00000001", d); end
        axil_read(5'h0C, d, r);
        total++; if (d !== 32'hB8) begin bad++; $display("FAIL ares_taps got=%h required=000000b8", d); end
        axil_read(5'h00, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ares_ctrl got=%h required=0", d); end
        axil_read(5'h14, d, r);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ares_sent got=%h required=0", d); end
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL ares_after tvalid=%b required=0", bus.m_axis_tvalid); end
    endtask

    initial begin
        bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0;  bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b1;
        bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b1;
        bus.m_axis_tready = 1'b0;
        test_reset();
        test_fibonacci();
        test_galois();
        test_stop_random();
        test_seed_zero();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, required finish before 1000000");
        $fatal(1, "watchdog");
    end
endmodule
